// File: rtl/rca_video_pkg.sv
// rca_video_pkg: types and constants shared by the RCA-style video path
// (line fetcher, CDP1861 display block).
package rca_video_pkg;

   // Line fetcher control state.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } lf_state_e;

   // Bytes fetched per display line unless overridden.
   localparam int unsigned BPL_DEFAULT = 8;

   // Pixels carried by one memory byte; the CDP1861 display block uses the same width.
   localparam int unsigned PIXEL_W = 8;

endpackage

// File: rtl/byte_fifo2.sv
// byte_fifo2: 2-entry DW-wide prefetch FIFO. A pop while empty but with a
// push in the same cycle passes the incoming byte straight through, so the
// shifter can load a byte in the very cycle it returns from memory.
module byte_fifo2 #(
   parameter int unsigned DW = 8
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [DW-1:0] din_i,
   input  logic          pop_i,
   output logic [DW-1:0] dout_o,
   output logic [1:0]    count_o
);

   logic [1:0][DW-1:0] mem_q;
   logic               wr_q;
   logic               rd_q;
   logic [1:0]         cnt_q;
   logic               wr_en;
   logic               rd_en;

   // Storage enables; the empty push+pop case never touches storage.
   always_comb begin
      rd_en  = pop_i && (cnt_q != 2'd0);
      wr_en  = push_i && !(pop_i && (cnt_q == 2'd0)) && ((cnt_q != 2'd2) || rd_en);
      dout_o = (cnt_q == 2'd0) ? din_i : mem_q[rd_q];
   end

   assign count_o = cnt_q;

   // Pointer, count and storage update.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else if (clr_i) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (wr_en) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= ~wr_q;
         end
         if (rd_en) begin
            rd_q <= ~rd_q;
         end
         cnt_q <= cnt_q + {1'b0, wr_en} - {1'b0, rd_en};
      end
   end

endmodule

// File: rtl/rom_line_fetch.sv
// rom_line_fetch: on start, reads BPL consecutive bytes from base through a
// one-cycle-latency memory port, buffers them in a 2-entry FIFO and shifts
// them out MSB-first, one pixel per ce, flagging any starvation as underrun.
module rom_line_fetch
   import rca_video_pkg::*;
#(
   parameter int unsigned DW  = PIXEL_W,
   parameter int unsigned AW  = 14,
   parameter int unsigned BPL = BPL_DEFAULT
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          ce,
   input  logic          start,
   input  logic [AW-1:0] base,
   output logic [AW-1:0] mem_a,
   output logic          mem_ce,
   input  logic [DW-1:0] mem_d,
   output logic          pixel,
   output logic          pixel_valid,
   output logic          busy,
   output logic          done,
   output logic          underrun
);

   localparam int unsigned   CW       = $clog2(BPL + 1);
   localparam int unsigned   BW       = $clog2(DW);
   localparam logic [CW-1:0] BPL_C    = CW'(BPL);
   localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

   lf_state_e     state_q;
   logic [AW-1:0] fa_q;
   logic [AW-1:0] mem_a_q;
   logic          mem_ce_q;
   logic          ret_q;
   logic [CW-1:0] rd_cnt_q;
   logic [CW-1:0] byte_cnt_q;
   logic [BW-1:0] bit_cnt_q;
   logic [DW-1:0] shift_q;
   logic          pix_vld_q;
   logic          busy_q;
   logic          done_q;
   logic          under_q;

   logic [DW-1:0] fifo_dout;
   logic [1:0]    fifo_cnt;
   logic          run;
   logic          start_go;
   logic          push;
   logic          avail;
   logic          owed;
   logic          slot_free;
   logic          pop;
   logic          starve;
   logic          line_end;
   logic [2:0]    occ_d;
   logic          rd_issue;

   // Shift-side decisions and the buffer occupancy that gates new reads.
   always_comb begin
      run       = (state_q == RUN);
      start_go  = (state_q == IDLE) && start;
      push      = ret_q;
      avail     = push || (fifo_cnt != 2'd0);
      owed      = (byte_cnt_q < BPL_C);
      slot_free = run && ce && (bit_cnt_q == '0);
      pop       = slot_free && owed && avail;
      // Waiting for the very first byte is not starvation, only a gap mid-line is.
      starve    = slot_free && owed && !avail && (byte_cnt_q != '0);
      line_end  = slot_free && !owed;
      // Bytes buffered after this edge plus the read whose data lands next cycle.
      occ_d     = {1'b0, fifo_cnt} + {2'b0, push} - {2'b0, pop} + {2'b0, mem_ce_q};
   end

   assign rd_issue = run && (rd_cnt_q < BPL_C) && (occ_d < 3'd2);

   byte_fifo2 #(.DW(DW)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .clr_i   (start_go),
      .push_i  (push),
      .din_i   (mem_d),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_cnt)
   );

   // Line FSM with fetch issue and pixel shifter; every output is a register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         fa_q       <= '0;
         mem_a_q    <= '0;
         mem_ce_q   <= 1'b0;
         ret_q      <= 1'b0;
         rd_cnt_q   <= '0;
         byte_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         pix_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         under_q    <= 1'b0;
      end else begin
         ret_q  <= mem_ce_q;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               mem_ce_q <= 1'b0;
               if (start) begin
                  state_q    <= RUN;
                  busy_q     <= 1'b1;
                  mem_a_q    <= base;
                  mem_ce_q   <= 1'b1;
                  fa_q       <= base + AW'(1);
                  rd_cnt_q   <= CW'(1);
                  byte_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  shift_q    <= '0;
                  pix_vld_q  <= 1'b0;
                  under_q    <= 1'b0;
               end
            end
            RUN: begin
               mem_ce_q <= rd_issue;
               if (rd_issue) begin
                  mem_a_q  <= fa_q;
                  fa_q     <= fa_q + AW'(1);
                  rd_cnt_q <= rd_cnt_q + CW'(1);
               end
               if (pop) begin
                  shift_q    <= fifo_dout;
                  bit_cnt_q  <= LAST_BIT;
                  pix_vld_q  <= 1'b1;
                  byte_cnt_q <= byte_cnt_q + CW'(1);
               end else if (ce && (bit_cnt_q != '0)) begin
                  shift_q   <= {shift_q[DW-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q - BW'(1);
               end else if (line_end) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  pix_vld_q <= 1'b0;
                  shift_q   <= '0;
               end else if (starve) begin
                  under_q   <= 1'b1;
                  pix_vld_q <= 1'b0;
                  shift_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_a       = mem_a_q;
   assign mem_ce      = mem_ce_q;
   assign pixel       = shift_q[DW-1];
   assign pixel_valid = pix_vld_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign underrun    = under_q;

endmodule

// File: tb/tb_rom_line_fetch.sv
// tb_rom_line_fetch: randomized line fetches against a queue/arithmetic
// reference: expected read addresses are base+n, expected pixels are the
// bits of the addressed bytes MSB-first, consumed only on ce cycles.
module tb_rom_line_fetch;

   localparam int DW   = 8;
   localparam int AW   = 14;
   localparam int BPL  = 8;
   localparam int BPL4 = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          ce = 1'b0;
   logic          start = 1'b0;
   logic          start4 = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW-1:0] base4 = 14'h3FFE;
   logic [AW-1:0] mem_a, mem_a4;
   logic          mem_ce, mem_ce4;
   logic [DW-1:0] mem_d = '0;
   logic [DW-1:0] mem_d4 = '0;
   logic          pixel, pixel_valid, busy, done, underrun;
   logic          pixel4, pixel_valid4, busy4, done4, underrun4;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          mem_mode = 0;
   int unsigned seed = 0;

   logic [AW-1:0] line_base;
   int            nrd, npix, rel;
   bit            tracking = 0, line_done, saw_under, exp_under, timed;
   logic [AW-1:0] line_base4 = 14'h3FFE;
   int            nrd4, npix4;
   bit            trk4 = 0, done4_seen;

   always #5 clock = ~clock;

   rom_line_fetch #(.DW(DW), .AW(AW), .BPL(BPL)) u_dut (
      .clock(clock), .reset_n(reset_n), .ce(ce), .start(start), .base(base),
      .mem_a(mem_a), .mem_ce(mem_ce), .mem_d(mem_d), .pixel(pixel),
      .pixel_valid(pixel_valid), .busy(busy), .done(done), .underrun(underrun)
   );

   rom_line_fetch #(.DW(DW), .AW(AW), .BPL(BPL4)) u_dut4 (
      .clock(clock), .reset_n(reset_n), .ce(ce), .start(start4), .base(base4),
      .mem_a(mem_a4), .mem_ce(mem_ce4), .mem_d(mem_d4), .pixel(pixel4),
      .pixel_valid(pixel_valid4), .busy(busy4), .done(done4), .underrun(underrun4)
   );

   function automatic logic [DW-1:0] mem_byte(input logic [AW-1:0] a);
      case (mem_mode)
         0:       return a[7:0];
         1:       return 8'hA5;
         default: return 8'((32'(a) * 37) ^ seed);
      endcase
   endfunction

   // Expected n-th pixel of a line: bit of byte base+n/DW, MSB first.
   function automatic logic bit_at(input logic [AW-1:0] b, input int n);
      logic [DW-1:0] by;
      by = mem_byte(AW'(32'(b) + n / DW));
      return by[DW-1 - (n % DW)];
   endfunction

   // Synchronous one-cycle-latency memory; garbage when not read.
   always @(posedge clock) begin
      if (mem_ce) mem_d <= mem_byte(mem_a);
      else        mem_d <= 8'($urandom);
      if (mem_ce4) mem_d4 <= mem_byte(mem_a4);
      else         mem_d4 <= 8'($urandom);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic mon();
      int started;
      if (tracking) begin
         if (rel == 1) begin
            chk("busy_c1", busy, 1);
            chk("mem_ce_c1", mem_ce, 1);
            chk("underrun_c1", underrun, 0);
         end
         if (mem_ce) begin
            chk("rd_addr", mem_a, AW'(32'(line_base) + nrd));
            nrd++;
            chk("rd_le_bpl", nrd <= BPL, 1);
         end
         started = pixel_valid ? (npix / DW + 1) : ((npix + DW - 1) / DW);
         chk("outstanding", (nrd - started) <= 2, 1);
         if (pixel_valid && ce) begin
            chk("pixel", pixel, bit_at(line_base, npix));
            npix++;
         end
         if (underrun && !saw_under) begin
            saw_under = 1;
            chk("starve_pv", pixel_valid, 0);
            chk("starve_pix", pixel, 0);
         end
         if (done) begin
            chk("pix_total", npix, BPL * DW);
            chk("rd_total", nrd, BPL);
            if (timed) chk("done_cycle", rel, 3 + BPL * DW);
            chk("underrun_done", underrun, exp_under);
            line_done = 1;
         end
      end
      if (trk4) begin
         if (mem_ce4) begin
            chk("rd_addr4", mem_a4, AW'(32'(line_base4) + nrd4));
            nrd4++;
         end
         if (pixel_valid4 && ce) begin
            chk("pixel4", pixel4, bit_at(line_base4, npix4));
            npix4++;
         end
         if (done4) begin
            chk("pix_total4", npix4, BPL4 * DW);
            chk("rd_total4", nrd4, BPL4);
            chk("underrun4", underrun4, 0);
            done4_seen = 1;
         end
      end
   endtask

   task automatic cyc(input logic ce_v, input logic st_v, input logic [AW-1:0] b_v, input logic st4_v);
      @(negedge clock);
      ce = ce_v; start = st_v; base = b_v; start4 = st4_v;
      rel++;
      mon();
   endtask

   // ce_mode: 0 always, 1 every 3rd cycle, 2 random.
   task automatic run_line(input logic [AW-1:0] b, input int ce_mode, input int stall_at,
                           input int stall_len, input bit exp_u, input int restart_at);
      logic ce_v, st_v;
      int   guard;
      line_base = b; nrd = 0; npix = 0; saw_under = 0; line_done = 0;
      exp_under = exp_u; timed = (ce_mode == 0) && (stall_len == 0);
      tracking = 1; rel = -1;
      cyc(1'b1, 1'b1, b, 1'b0);
      guard = 0;
      while (!line_done && guard < 3000) begin
         guard++;
         if (stall_len > 0 && rel + 1 == stall_at) force u_dut.rd_issue = 1'b0;
         if (stall_len > 0 && rel + 1 == stall_at + stall_len) release u_dut.rd_issue;
         case (ce_mode)
            0:       ce_v = 1'b1;
            1:       ce_v = ((rel + 1) % 3 == 0);
            default: ce_v = ($urandom_range(0, 3) != 0);
         endcase
         st_v = (rel + 1 == restart_at);
         cyc(ce_v, st_v, st_v ? (b ^ 14'h1555) : b, 1'b0);
      end
      if (stall_len > 0) begin
         release u_dut.rd_issue;
         chk("saw_underrun", saw_under, 1);
      end
      chk("line_done", line_done, 1);
      tracking = 0;
      cyc(1'b0, 1'b0, b, 1'b0);
      chk("busy_after", busy, 0);
   endtask

   task automatic run_wrap();
      int guard;
      nrd4 = 0; npix4 = 0; done4_seen = 0; trk4 = 1;
      cyc(1'b1, 1'b0, '0, 1'b1);
      guard = 0;
      while (!done4_seen && guard < 1000) begin
         guard++;
         cyc(1'b1, 1'b0, '0, 1'b0);
      end
      chk("line_done4", done4_seen, 1);
      trk4 = 0;
      cyc(1'b0, 1'b0, '0, 1'b0);
      chk("busy_after4", busy4, 0);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      #1;
      chk("rst_outs", {mem_a, mem_ce, pixel, pixel_valid, busy, done, underrun}, 0);
      chk("rst_outs4", {mem_a4, mem_ce4, pixel_valid4, busy4, done4, underrun4}, 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) cyc(1'b1, 1'b0, '0, 1'b0);

      // Address-low-byte memory, ce always high: exact 64-pixel line timing.
      mem_mode = 0;
      run_line(14'h0100, 0, 0, 0, 1'b0, 0);

      // Address wrap with the 4-byte instance.
      run_wrap();

      // Constant 0xA5, ce every third cycle.
      mem_mode = 1;
      run_line(14'($urandom), 1, 0, 0, 1'b0, 0);

      // Reads withheld long enough to drain the buffer: underrun, order kept.
      mem_mode = 2; seed = $urandom;
      run_line(14'h2345, 0, 3, 40, 1'b1, 0);

      // Next start clears underrun; a mid-line start is ignored.
      run_line(14'h0ABC, 2, 0, 0, 1'b0, 30);

      // Reset for one cycle mid-line.
      line_base = 14'h1F00; nrd = 0; npix = 0; saw_under = 0; line_done = 0;
      exp_under = 0; timed = 0; tracking = 1; rel = -1;
      cyc(1'b1, 1'b1, 14'h1F00, 1'b0);
      repeat (20) cyc(1'b1, 1'b0, 14'h1F00, 1'b0);
      tracking = 0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("abort_outs", {mem_a, mem_ce, pixel, pixel_valid, busy, done, underrun}, 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (4) begin
         cyc(1'b1, 1'b0, 14'h1F00, 1'b0);
         chk("post_rst_idle", {busy, mem_ce, pixel_valid, done, underrun}, 0);
      end
      run_line(14'h1F40, 0, 0, 0, 1'b0, 0);

      // A few fully random lines.
      for (int i = 0; i < 3; i++) begin
         seed = $urandom;
         run_line(14'($urandom), 2, 0, 0, 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
